// File: rtl/instr_fetch_unit.sv
// Instruction fetch stage: owns the PC, reads the instruction cache, and buffers
// {pc, instr} pairs in a small queue that decode drains with a valid/ready handshake.

module instr_fetch_unit_chk #(
    parameter int FQ_DEPTH = 2,
    parameter int CW       = 2
) (
    input  logic          clk,
    input  logic          rst,
    input  logic [CW-1:0] count,
    input  logic          pop
);

    a_no_overflow: assert property (@(posedge clk) disable iff (!rst)
        count <= CW'(FQ_DEPTH));

    a_no_empty_pop: assert property (@(posedge clk) disable iff (!rst)
        !(pop && (count == '0)));

endmodule

module instr_fetch_unit #(
    parameter logic [31:0] RESET_PC = 32'h0000_0000,
    parameter int          FQ_DEPTH = 2
) (
    input  logic                       clk,
    input  logic                       rst,
    output logic [31:0]                imem_addr,
    input  logic [31:0]                imem_rdata,
    input  logic                       redirect_valid,
    input  logic [31:0]                redirect_target,
    output logic                       if_valid,
    output logic [31:0]                if_instr,
    output logic [31:0]                if_pc,
    input  logic                       if_ready,
    output logic [$clog2(FQ_DEPTH):0]  fq_count,
    output logic                       fault,
    output logic [31:0]                fault_pc
);

    localparam int PW = $clog2(FQ_DEPTH);
    localparam int CW = PW + 1;
    localparam logic [CW-1:0] DEPTH_C = CW'(FQ_DEPTH);

    typedef enum logic [0:0] {
        ST_RUN   = 1'b0,
        ST_FAULT = 1'b1
    } state_t;

    state_t          state_r;
    state_t          state_nxt_s;
    logic [31:0]     pc_r;
    logic [31:0]     pc_nxt_s;
    logic [CW-1:0]   count_r;
    logic [CW-1:0]   count_nxt_s;
    logic [PW-1:0]   wr_ptr_r;
    logic [PW-1:0]   wr_ptr_nxt_s;
    logic [PW-1:0]   rd_ptr_r;
    logic [PW-1:0]   rd_ptr_nxt_s;
    logic            fault_r;
    logic            fault_nxt_s;
    logic [31:0]     fault_pc_r;
    logic [31:0]     fault_pc_nxt_s;
    logic [63:0]     fq_mem_r [FQ_DEPTH];
    logic [63:0]     head_s;
    logic            run_s;
    logic            pop_s;
    logic            push_s;

    assign imem_addr = pc_r;
    assign fq_count  = count_r;
    assign fault     = fault_r;
    assign fault_pc  = fault_pc_r;
    assign if_valid  = (count_r != '0);
    assign head_s    = fq_mem_r[rd_ptr_r];
    assign pop_s     = if_valid & if_ready;

    // Decode whether the FSM currently permits fetching.
    always_comb begin
        run_s = 1'b0;
        case (state_r)
            ST_RUN:   run_s = 1'b1;
            ST_FAULT: run_s = 1'b0;
            default:  run_s = 1'b0;
        endcase
    end

    // A full queue can still accept a fetch when decode drains the head this cycle.
    always_comb begin
        if (run_s && !redirect_valid) begin
            push_s = (count_r < DEPTH_C) || ((count_r == DEPTH_C) && pop_s);
        end else begin
            push_s = 1'b0;
        end
    end

    // Next-state and datapath update; a redirect flushes and overrides any fetch.
    always_comb begin
        state_nxt_s    = state_r;
        pc_nxt_s       = pc_r;
        count_nxt_s    = count_r;
        wr_ptr_nxt_s   = wr_ptr_r;
        rd_ptr_nxt_s   = rd_ptr_r;
        fault_nxt_s    = fault_r;
        fault_pc_nxt_s = fault_pc_r;
        if (redirect_valid) begin
            pc_nxt_s     = redirect_target;
            count_nxt_s  = '0;
            wr_ptr_nxt_s = '0;
            rd_ptr_nxt_s = '0;
            if (redirect_target[1:0] == 2'b00) begin
                state_nxt_s = ST_RUN;
                fault_nxt_s = 1'b0;
            end else begin
                state_nxt_s    = ST_FAULT;
                fault_nxt_s    = 1'b1;
                fault_pc_nxt_s = redirect_target;
            end
        end else begin
            if (push_s) begin
                pc_nxt_s     = pc_r + 32'd4;
                wr_ptr_nxt_s = wr_ptr_r + PW'(1);
            end else begin
                pc_nxt_s     = pc_r;
                wr_ptr_nxt_s = wr_ptr_r;
            end
            if (pop_s) begin
                rd_ptr_nxt_s = rd_ptr_r + PW'(1);
            end else begin
                rd_ptr_nxt_s = rd_ptr_r;
            end
            if (push_s && !pop_s) begin
                count_nxt_s = count_r + CW'(1);
            end else if (!push_s && pop_s) begin
                count_nxt_s = count_r - CW'(1);
            end else begin
                count_nxt_s = count_r;
            end
        end
    end

    // Control and status registers.
    always_ff @(posedge clk) begin
        if (!rst) begin
            state_r    <= ST_RUN;
            pc_r       <= RESET_PC;
            count_r    <= '0;
            wr_ptr_r   <= '0;
            rd_ptr_r   <= '0;
            fault_r    <= 1'b0;
            fault_pc_r <= 32'h0000_0000;
        end else begin
            state_r    <= state_nxt_s;
            pc_r       <= pc_nxt_s;
            count_r    <= count_nxt_s;
            wr_ptr_r   <= wr_ptr_nxt_s;
            rd_ptr_r   <= rd_ptr_nxt_s;
            fault_r    <= fault_nxt_s;
            fault_pc_r <= fault_pc_nxt_s;
        end
    end

    // Queue storage; each entry is {pc, instr}.
    always_ff @(posedge clk) begin
        if (!rst) begin
            for (int i = 0; i < FQ_DEPTH; i++) begin
                fq_mem_r[i] <= 64'h0;
            end
        end else if (push_s) begin
            fq_mem_r[wr_ptr_r] <= {pc_r, imem_rdata};
        end else begin
            fq_mem_r[wr_ptr_r] <= fq_mem_r[wr_ptr_r];
        end
    end

    // Head presentation; an empty queue shows zeros rather than stale data.
    always_comb begin
        if (count_r != '0) begin
            if_pc    = head_s[63:32];
            if_instr = head_s[31:0];
        end else begin
            if_pc    = 32'h0000_0000;
            if_instr = 32'h0000_0000;
        end
    end

    instr_fetch_unit_chk #(
        .FQ_DEPTH (FQ_DEPTH),
        .CW       (CW)
    ) u_chk (
        .clk   (clk),
        .rst   (rst),
        .count (count_r),
        .pop   (pop_s)
    );

endmodule

// File: tb/tb_instr_fetch_unit.sv
// Scoreboard bench for instr_fetch_unit: directed stimulus pushes expected
// {pc, instr} pairs, a negedge monitor pops and compares every accepted delivery.

module tb_instr_fetch_unit;

    logic        clk;
    logic        rst;
    logic [31:0] imem_addr;
    logic [31:0] imem_rdata;
    logic        redirect_valid;
    logic [31:0] redirect_target;
    logic        if_valid;
    logic [31:0] if_instr;
    logic [31:0] if_pc;
    logic        if_ready;
    logic [1:0]  fq_count;
    logic        fault;
    logic [31:0] fault_pc;

    logic        rst2;
    logic [31:0] imem_addr2;
    logic [31:0] imem_rdata2;
    logic        redirect_valid2;
    logic [31:0] redirect_target2;
    logic        if_valid2;
    logic [31:0] if_instr2;
    logic [31:0] if_pc2;
    logic        if_ready2;
    logic [1:0]  fq_count2;
    logic        fault2;
    logic [31:0] fault_pc2;

    int          n_checks;
    int          n_fail;
    logic [63:0] exp_q [$];

    // Cache model: a distinct word for every address.
    function automatic logic [31:0] word(input logic [31:0] a);
        return (a * 32'h0001_0003) ^ 32'hC0DE_1234;
    endfunction

    assign imem_rdata  = word(imem_addr);
    assign imem_rdata2 = word(imem_addr2);

    instr_fetch_unit #(.RESET_PC(32'h0000_0000), .FQ_DEPTH(2)) dut (
        .clk(clk), .rst(rst), .imem_addr(imem_addr), .imem_rdata(imem_rdata),
        .redirect_valid(redirect_valid), .redirect_target(redirect_target),
        .if_valid(if_valid), .if_instr(if_instr), .if_pc(if_pc), .if_ready(if_ready),
        .fq_count(fq_count), .fault(fault), .fault_pc(fault_pc)
    );

    instr_fetch_unit #(.RESET_PC(32'hFFFF_FFFC), .FQ_DEPTH(2)) dut2 (
        .clk(clk), .rst(rst2), .imem_addr(imem_addr2), .imem_rdata(imem_rdata2),
        .redirect_valid(redirect_valid2), .redirect_target(redirect_target2),
        .if_valid(if_valid2), .if_instr(if_instr2), .if_pc(if_pc2), .if_ready(if_ready2),
        .fq_count(fq_count2), .fault(fault2), .fault_pc(fault_pc2)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h at %0t", nm, act, exp, $time);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic exp_push(input logic [31:0] pc);
        exp_q.push_back({pc, word(pc)});
    endtask

    // Monitor: every accepted head must match the next expected entry.
    initial begin : monitor
        logic [63:0] e;
        forever begin
            @(negedge clk);
            if (rst && if_valid && if_ready) begin
                if (exp_q.size() == 0) begin
                    n_checks++;
                    n_fail++;
                    $display("FAIL unexpected_delivery: got if_pc %h expected none at %0t", if_pc, $time);
                end else begin
                    e = exp_q.pop_front();
                    chk("deliver_pc", if_pc, e[63:32]);
                    chk("deliver_instr", if_instr, e[31:0]);
                end
            end
        end
    end

    initial begin : watchdog
        #200000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog expired");
    end

    initial begin : stim
        n_checks = 0;
        n_fail   = 0;
        rst = 1'b0; if_ready = 1'b1; redirect_valid = 1'b0; redirect_target = 32'h0;
        rst2 = 1'b0; if_ready2 = 1'b1; redirect_valid2 = 1'b0; redirect_target2 = 32'h0;

        // Test 1: reset state, then streaming from RESET_PC with no bubbles.
        repeat (2) tick();
        chk("rst_count", 32'(fq_count), 32'd0);
        chk("rst_valid", 32'(if_valid), 32'd0);
        chk("rst_pc", if_pc, 32'h0);
        chk("rst_instr", if_instr, 32'h0);
        chk("rst_addr", imem_addr, 32'h0);
        chk("rst_fault", 32'(fault), 32'd0);
        chk("rst_fault_pc", fault_pc, 32'h0);
        rst = 1'b1;
        chk("t1_c0_addr", imem_addr, 32'h0);
        chk("t1_c0_valid", 32'(if_valid), 32'd0);
        for (int i = 0; i < 4; i++) exp_push(32'(i * 4));
        for (int i = 0; i < 4; i++) begin
            tick();
            chk("t1_valid", 32'(if_valid), 32'd1);
            chk("t1_pc", if_pc, 32'(i * 4));
        end
        tick();
        if_ready = 1'b0;
        rst = 1'b0;

        // Test 2: backpressure saturates the queue and stalls the pc.
        repeat (2) tick();
        rst = 1'b1;
        tick();
        chk("t2_c1_count", 32'(fq_count), 32'd1);
        chk("t2_c1_pc", if_pc, 32'h0);
        for (int c = 2; c <= 5; c++) begin
            tick();
            chk("t2_count", 32'(fq_count), 32'd2);
            chk("t2_addr", imem_addr, 32'h8);
            chk("t2_head_pc", if_pc, 32'h0);
            chk("t2_head_instr", if_instr, word(32'h0));
        end
        for (int i = 0; i < 5; i++) exp_push(32'(i * 4));
        tick();
        if_ready = 1'b1;
        chk("t2_c6_pc", if_pc, 32'h0);
        for (int i = 1; i < 4; i++) begin
            tick();
            chk("t2_drain_pc", if_pc, 32'(i * 4));
        end

        // Test 3: redirect while full and the head is accepted that cycle.
        tick();
        chk("t3_full", 32'(fq_count), 32'd2);
        chk("t3_head", if_pc, 32'h10);
        redirect_valid = 1'b1; redirect_target = 32'h28;
        tick();
        redirect_valid = 1'b0;
        chk("t3_flush_valid", 32'(if_valid), 32'd0);
        chk("t3_flush_count", 32'(fq_count), 32'd0);
        chk("t3_flush_addr", imem_addr, 32'h28);
        exp_push(32'h28); exp_push(32'h2C);
        tick();
        chk("t3_tgt0", if_pc, 32'h28);
        tick();
        chk("t3_tgt1", if_pc, 32'h2C);

        // Test 4: misaligned redirect halts fetch until an aligned redirect.
        tick();
        if_ready = 1'b0;
        redirect_valid = 1'b1; redirect_target = 32'h56;
        tick();
        redirect_valid = 1'b0;
        if_ready = 1'b1;
        for (int i = 0; i < 10; i++) begin
            chk("t4_fault", 32'(fault), 32'd1);
            chk("t4_fault_pc", fault_pc, 32'h56);
            chk("t4_valid", 32'(if_valid), 32'd0);
            chk("t4_addr", imem_addr, 32'h56);
            tick();
        end
        redirect_valid = 1'b1; redirect_target = 32'h63;
        tick();
        chk("t4_refault", 32'(fault), 32'd1);
        chk("t4_refault_pc", fault_pc, 32'h63);
        redirect_target = 32'h40;
        tick();
        redirect_valid = 1'b0;
        chk("t4_clear", 32'(fault), 32'd0);
        chk("t4_clear_valid", 32'(if_valid), 32'd0);
        chk("t4_clear_addr", imem_addr, 32'h40);
        exp_push(32'h40); exp_push(32'h44);
        tick();
        chk("t4_tgt0", if_pc, 32'h40);
        tick();
        chk("t4_tgt1", if_pc, 32'h44);

        // Test 6: reset mid-stream with a full queue.
        tick();
        if_ready = 1'b0;
        tick();
        chk("t6_full", 32'(fq_count), 32'd2);
        chk("t6_nofault", 32'(fault), 32'd0);
        rst = 1'b0;
        tick();
        chk("t6_count", 32'(fq_count), 32'd0);
        chk("t6_valid", 32'(if_valid), 32'd0);
        chk("t6_addr", imem_addr, 32'h0);
        chk("t6_pc", if_pc, 32'h0);
        chk("t6_fault_pc", fault_pc, 32'h0);
        rst = 1'b1;
        if_ready = 1'b1;
        exp_push(32'h0); exp_push(32'h4);
        chk("t6_c0_addr", imem_addr, 32'h0);
        tick();
        chk("t6_c1_pc", if_pc, 32'h0);
        chk("t6_c1_instr", if_instr, word(32'h0));
        tick();
        chk("t6_c2_pc", if_pc, 32'h4);
        tick();
        if_ready = 1'b0;

        // Test 5: pc wrap-around from RESET_PC = 0xFFFFFFFC.
        rst2 = 1'b1;
        chk("t5_c0_addr", imem_addr2, 32'hFFFF_FFFC);
        tick();
        chk("t5_c1_valid", 32'(if_valid2), 32'd1);
        chk("t5_c1_pc", if_pc2, 32'hFFFF_FFFC);
        chk("t5_c1_instr", if_instr2, word(32'hFFFF_FFFC));
        tick();
        chk("t5_c2_pc", if_pc2, 32'h0);
        chk("t5_c2_instr", if_instr2, word(32'h0));
        tick();
        chk("t5_c3_pc", if_pc2, 32'h4);

        tick();
        chk("scoreboard_empty", 32'(exp_q.size()), 32'd0);
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
